// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA at BASE_ADDR, STATUS/CTRL at BASE_ADDR+4, 8-entry FIFO, 8N1 framing.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_p,
  input  logic        i_MemWrite,
  input  logic [31:0] i_DataAdr,
  input  logic [31:0] i_WriteData,
  output logic [31:0] o_ReadData,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_fifo_full,
  output logic        o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MMIO_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   baud_q, baud_n;
  logic [2:0]      idx_q, idx_n;
  logic [7:0]      shift_q, shift_n;
  logic            par_q, par_n;
  logic            tx_q, tx_n;
  logic            pop, push, start_frame;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf_q;
  logic            empty, full, busy;
  logic            wr_data_sel, wr_ctrl_sel;
  logic [31:0]     count_w;
  logic [3:0]      cnt_disp;
  logic            unused_wdata;

  assign unused_wdata = ^i_WriteData[31:8];

  assign wr_data_sel = i_MemWrite && (i_DataAdr == BASE_ADDR);
  assign wr_ctrl_sel = i_MemWrite && (i_DataAdr == BASE_ADDR + 32'd4);
  assign empty       = (count == '0);
  assign full        = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a byte when the FSM pops on the same edge.
  assign push        = wr_data_sel && (!full || pop);
  assign busy        = (state_q != IDLE) || !empty;

  always_comb begin
    state_n     = state_q;
    baud_n      = baud_q;
    idx_n       = idx_q;
    shift_n     = shift_q;
    par_n       = par_q;
    tx_n        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) start_frame = 1'b1;
      end
      START: begin
        if (baud_q != '0) baud_n = baud_q - 1'b1;
        else begin
          baud_n  = BAUD_LOAD;
          idx_n   = 3'd0;
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_q != '0) baud_n = baud_q - 1'b1;
        else begin
          baud_n = BAUD_LOAD;
          if (idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shift_n = {1'b0, shift_q[7:1]};
            idx_n   = idx_q + 3'd1;
            tx_n    = shift_q[1];
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        if (baud_q != '0) baud_n = baud_q - 1'b1;
        else begin
          baud_n  = BAUD_LOAD;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_q != '0) baud_n = baud_q - 1'b1;
        else if (!empty) start_frame = 1'b1;
        else begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
    // Pop and launch the start bit on the same edge, so frames run back to back.
    if (start_frame) begin
      pop     = 1'b1;
      shift_n = mem[rd_ptr];
      par_n   = ^mem[rd_ptr];
      baud_n  = BAUD_LOAD;
      state_n = START;
      tx_n    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_p) begin
    if (i_rst_p) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_p) begin
    if (i_rst_p) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_data_sel && !push)                ovf_q <= 1'b1;
      else if (wr_ctrl_sel && i_WriteData[0])  ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_WriteData[7:0];
  end

  assign count_w  = 32'(count);
  assign cnt_disp = (count_w > 32'd15) ? 4'hF : count_w[3:0];

  always_comb begin
    o_ReadData = 32'h0;
    if (i_DataAdr == BASE_ADDR + 32'd4)
      o_ReadData = {24'h0, cnt_disp, ovf_q, busy, full, empty};
  end

  assign o_tx        = tx_q;
  assign o_busy      = busy;
  assign o_fifo_full = full;
  assign o_overflow  = ovf_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random byte streams checked against a slot-based line model.
module tb_mmio_uart_tx;
  localparam int CPB = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef MMIO_UART_PARITY_EN
  localparam int F = 11 * CPB;
`else
  localparam int F = 10 * CPB;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_p = 1'b1;
  logic        i_MemWrite = 1'b0;
  logic [31:0] i_DataAdr = 32'h0;
  logic [31:0] i_WriteData = 32'h0;
  logic [31:0] o_ReadData;
  logic        o_tx, o_busy, o_fifo_full, o_overflow;

  mmio_uart_tx dut (
    .i_clk(i_clk), .i_rst_p(i_rst_p), .i_MemWrite(i_MemWrite),
    .i_DataAdr(i_DataAdr), .i_WriteData(i_WriteData), .o_ReadData(o_ReadData),
    .o_tx(o_tx), .o_busy(o_busy), .o_fifo_full(o_fifo_full), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  logic [7:0] txq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level t cycles after the start bit begins: slot 0 start, 1..8 data LSB first, optional parity, then stop/idle.
  function automatic logic exp_tx(input logic [7:0] b, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef MMIO_UART_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_MemWrite = 1'b1; i_DataAdr = a; i_WriteData = d;
    @(negedge i_clk);
    i_MemWrite = 1'b0; i_DataAdr = 32'h0; i_WriteData = 32'h0;
  endtask

  // Writes txq on consecutive cycles while sampling the line, then checks every frame and the busy window.
  task automatic send_check(input string tag);
    int n, len, errs;
    logic gt[$];
    logic gb[$];
    n = txq.size();
    len = n * F + 2;
    for (int c = 0; c < len; c++) begin
      if (c < n) begin
        i_MemWrite = 1'b1; i_DataAdr = BASE; i_WriteData = {24'($urandom), txq[c]};
      end else begin
        i_MemWrite = 1'b0; i_DataAdr = 32'h0; i_WriteData = 32'h0;
      end
      @(negedge i_clk);
      gt.push_back(o_tx);
      gb.push_back(o_busy);
    end
    chk({tag, "_pre_idle"}, 32'(gt[0]), 32'h1);
    for (int j = 0; j < n; j++) begin
      errs = 0;
      for (int t = 0; t < F; t++)
        if (gt[1 + j*F + t] !== exp_tx(txq[j], t)) errs++;
      chk({tag, "_frame_errs"}, errs, 0);
    end
    errs = 0;
    for (int s = 0; s <= n*F; s++) if (gb[s] !== 1'b1) errs++;
    chk({tag, "_busy_errs"}, errs, 0);
    chk({tag, "_end_tx"}, 32'(gt[len-1]), 32'h1);
    chk({tag, "_end_busy"}, 32'(gb[len-1]), 32'h0);
    txq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rel, rel_low, errs;
    logic dr[int];
    logic [7:0] bb;

    // reset state
    repeat (2) @(negedge i_clk);
    i_DataAdr = BASE + 32'd4; #1;
    chk("rst_tx", 32'(o_tx), 32'h1);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_full", 32'(o_fifo_full), 32'h0);
    chk("rst_ovf", 32'(o_overflow), 32'h0);
    chk("rst_status", o_ReadData, 32'h1);
    i_DataAdr = 32'h0;
    @(negedge i_clk);
    i_rst_p = 1'b0;
    @(negedge i_clk);

    txq = '{8'hA5};
    send_check("single");
    txq = '{8'h55, 8'h0F};
    send_check("b2b");
    repeat (3) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
      send_check("rand");
    end

    // decode: only exact addresses act
    wr(32'h0000_1001, 32'h0000_00FF);
    wr(32'h0000_0FFC, 32'h0000_00FF);
    wr(32'h0000_1008, 32'h0000_00FF);
    repeat (3) @(negedge i_clk);
    chk("dec_busy", 32'(o_busy), 32'h0);
    chk("dec_tx", 32'(o_tx), 32'h1);
    i_DataAdr = BASE + 32'd4; #1;
    chk("dec_status", o_ReadData, 32'h1);
    i_DataAdr = BASE; #1;
    chk("dec_rd_txdata", o_ReadData, 32'h0);
    i_DataAdr = BASE + 32'd5; #1;
    chk("dec_rd_1005", o_ReadData, 32'h0);
    i_DataAdr = 32'h0;
    @(negedge i_clk);

    // overflow: one frame in flight, then 9 more writes
    wr(BASE, 32'h11);
    rel = 0;
    repeat (3) @(negedge i_clk);
    rel += 3;
    for (int k = 0; k < 9; k++) begin
      wr(BASE, 32'h20 + k);
      rel++;
      if (k == 6) chk("ovf_full_after7", 32'(o_fifo_full), 32'h0);
      if (k == 7) begin
        chk("ovf_full_after8", 32'(o_fifo_full), 32'h1);
        chk("ovf_flag_after8", 32'(o_overflow), 32'h0);
      end
    end
    chk("ovf_full_after9", 32'(o_fifo_full), 32'h1);
    chk("ovf_flag_after9", 32'(o_overflow), 32'h1);
    i_DataAdr = BASE + 32'd4; #1;
    chk("ovf_status", o_ReadData, 32'h8E);
    i_DataAdr = 32'h0;
    wr(BASE + 32'd4, 32'h2);
    rel++;
    chk("ovf_noclear_bit1", 32'(o_overflow), 32'h1);
    wr(BASE + 32'd4, 32'h1);
    rel++;
    chk("ovf_clear", 32'(o_overflow), 32'h0);
    rel_low = -1;
    for (int r = rel + 1; r < 9*F + 40; r++) begin
      @(negedge i_clk);
      dr[r] = o_tx;
      if (!o_busy) begin
        rel_low = r;
        break;
      end
    end
    chk("ovf_drain_time", rel_low, 9*F + 1);
    for (int k = 1; k <= 8; k++) begin
      bb = 8'h20 + 8'(k - 1);
      errs = 0;
      for (int t = 0; t < F; t++)
        if (!dr.exists(1 + k*F + t) || dr[1 + k*F + t] !== exp_tx(bb, t)) errs++;
      chk("ovf_drain_frame", errs, 0);
    end
    i_DataAdr = BASE + 32'd4; #1;
    chk("ovf_drain_status", o_ReadData, 32'h1);
    i_DataAdr = 32'h0;
    @(negedge i_clk);

    // reset during data bit 3 (a low bit of 0xA5)
    wr(BASE, 32'hA5);
    repeat (72) @(negedge i_clk);
    chk("mid_tx_before", 32'(o_tx), 32'(exp_tx(8'hA5, 71)));
    i_rst_p = 1'b1; #1;
    chk("mid_rst_tx", 32'(o_tx), 32'h1);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    i_DataAdr = BASE + 32'd4; #1;
    chk("mid_rst_status", o_ReadData, 32'h1);
    @(negedge i_clk);
    i_rst_p = 1'b0;
    i_DataAdr = 32'h0;
    @(negedge i_clk);
    chk("mid_post_tx", 32'(o_tx), 32'h1);
    txq.push_back(8'($urandom));
    send_check("after_rst");

`ifdef MMIO_UART_PARITY_EN
    txq = '{8'h07};
    send_check("par07");
    txq = '{8'h03};
    send_check("par03");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-memory write bus (MemWrite / DataAdr / WriteData), alongside data_memory.
- Stores written bytes into a small FIFO and serialises them on a single TX line. This gives the single-cycle core a console/trace output.
- Provides a readable status word for polling.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of the TXDATA register. The STATUS/CTRL register is at BASE_ADDR+4.
- CLKS_PER_BIT, 16: i_clk cycles per serial bit. Must be ≥2.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, ≥2.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst_p  in  1  asynchronous reset, active high.
- i_MemWrite  in  1  data-memory write enable from the core.
- i_DataAdr  in  32  data byte address from the core.
- i_WriteData  in  32  store data from the core.
- o_ReadData  out  32  combinational status readback.
- o_tx  out  1  serial output, registered, idle high.
- o_busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.
- o_fifo_full  out  1  FIFO count == FIFO_DEPTH.
- o_overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (async, i_rst_p=1):
  - FIFO empty (count=0, pointers 0), FSM=IDLE, baud counter 0.
  - o_tx=1, o_overflow=0, o_busy=0, o_fifo_full=0.
  - Applies immediately, including mid-frame. The line returns high with no glitch low.
- Address decode: full 32-bit equality compare. Any other address, including BASE_ADDR+1..3, is ignored.
- Write to BASE_ADDR: push i_WriteData[7:0].
  - The push is accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge (count unchanged).
  - Otherwise the byte is dropped and o_overflow is set.
- Write to BASE_ADDR+4 with i_WriteData[0]=1: clears o_overflow. If a set and a clear occur on the same edge, the set wins.
- o_ReadData: when i_DataAdr==BASE_ADDR+4, returns {24'b0, count[3:0], overflow, busy, full, empty}. For any other address it returns 0. count saturates its display at 15.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If the FIFO is not empty, pop into an 8-bit shift register, load the baud counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle, if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Latency: a TXDATA write captured on edge N makes the byte visible in the FIFO after N. The IDLE pop occurs at N+1, so o_tx falls after edge N+1. A frame is 10*CLKS_PER_BIT cycles.
- o_tx is driven from a flop; it never glitches combinationally.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT (8E1).
- Undefined: no PARITY state; frame = 10*CLKS_PER_BIT (8N1).

Test Plan:
- Single byte: reset, then write 0x0000_00A5 to 0x1000. o_tx falls 2 edges after the write and stays low 16 cycles. Bits 1,0,1,0,0,1,0,1 follow (16 cycles each), then stop high. o_busy drops after 160 cycles.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles. The second start bit immediately follows the first stop bit, with no idle cycles; total 320 busy cycles.
- Overflow: with the FSM busy, write 9 bytes. o_fifo_full=1 after the 8th. The 9th is dropped and o_overflow=1. A STATUS read at 0x1004 returns 0x8E: count 8, overflow set, busy set, full set, empty clear. Write 0x1 to 0x1004 → o_overflow=0.
- Decode: writes to 0x1001, 0x0FFC and 0x1008 leave the FIFO empty and o_tx=1. A read of 0x1000 returns 0.
- Reset mid-frame: assert i_rst_p during DATA bit 3. o_tx=1 immediately, the FIFO is empty, and a new write afterwards transmits cleanly.
- Parity (macro defined): write 0x07 → parity bit 1 and a frame length of 176 cycles. Write 0x03 → parity bit 0.
